// File: rtl/filter_coeff_arb_pkg.sv
// Shared filter definitions: coefficient bus defaults and the one-hot
// encoding of the host/filter coefficient RAM arbiter FSM.
package filter_coeff_arb_pkg;

  localparam int FILT_PTR_DEFAULT          = 9;
  localparam int FILT_WIDTH_DEFAULT        = 16;
  localparam int FILT_STARVE_LIMIT_DEFAULT = 1023;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_PEND   = 4'b0010,
    ST_ACCESS = 4'b0100,
    ST_ACK    = 4'b1000
  } arb_state_e;

  // Host is waiting for the RAM in these states.
  function automatic logic arb_is_waiting(input arb_state_e st);
    return (st == ST_PEND) || (st == ST_ACCESS);
  endfunction

endpackage

// File: rtl/filter_coeff_arb_starve_cnt.sv
// Host starvation counter: counts waiting cycles, raises a sticky flag when
// the count reaches LIMIT; a clear request beats a same-cycle set.
module filter_starve_cnt
  import filter_coeff_arb_pkg::*;
#(
  parameter int LIMIT = FILT_STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rstb,
  input  logic cnt_en,
  input  logic cnt_clr,
  input  logic starve_clr,
  output logic starve
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C   = CW'(LIMIT);
  localparam logic [CW-1:0] LIMIT_M1C = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          starve_reg, starve_next;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_reg    <= '0;
      starve_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      starve_reg <= starve_next;
    end
  end

  // Count saturates at LIMIT; the flag sets only on the step into LIMIT so a
  // clear during a continuing stall is not immediately undone.
  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clr)
      cnt_next = '0;
    else if (cnt_en && (cnt_reg != LIMIT_C))
      cnt_next = cnt_reg + 1'b1;

    starve_next = starve_reg;
    if (starve_clr)
      starve_next = 1'b0;
    else if (cnt_en && !cnt_clr && (cnt_reg == LIMIT_M1C))
      starve_next = 1'b1;
  end

  assign starve = starve_reg;

endmodule

// File: rtl/filter_coeff_arb.sv
// Coefficient RAM arbiter: filter reads have strict priority, host register
// accesses slip in on idle cycles. Starvation flag built with FILTER_COEFF_ARB_STARVE_EN.
module filter_coeff_arb
  import filter_coeff_arb_pkg::*;
#(
  parameter int PTR          = FILT_PTR_DEFAULT,
  parameter int WIDTH        = FILT_WIDTH_DEFAULT,
  parameter int STARVE_LIMIT = FILT_STARVE_LIMIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             filt_re,
  input  logic [PTR-1:0]   filt_rdptr,
  output logic [WIDTH-1:0] filt_coeff,
  output logic             filt_coeff_vld,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [PTR-1:0]   host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_ack,
  output logic [WIDTH-1:0] host_rdata,
  output logic             ram_cs,
  output logic             ram_we,
  output logic [PTR-1:0]   ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  input  logic             starve_clr,
  output logic             host_starve
);

  arb_state_e       state_reg, state_next;
  logic             hold_we_reg;
  logic [PTR-1:0]   hold_addr_reg;
  logic [WIDTH-1:0] hold_wdata_reg;
  logic             filt_vld_reg;
  logic             host_rd_en;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (host_req) state_next = ST_PEND;
      ST_PEND:   if (!filt_re) state_next = ST_ACCESS;
      ST_ACCESS: state_next = filt_re ? ST_PEND : ST_ACK;
      ST_ACK:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Request fields are latched once so the host may not hold them stable.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hold_we_reg    <= 1'b0;
      hold_addr_reg  <= '0;
      hold_wdata_reg <= '0;
    end else if ((state_reg == ST_IDLE) && host_req) begin
      hold_we_reg    <= host_we;
      hold_addr_reg  <= host_addr;
      hold_wdata_reg <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      filt_vld_reg <= 1'b0;
    else
      filt_vld_reg <= filt_re;
  end

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (filt_re) begin
      ram_cs   = 1'b1;
      ram_addr = filt_rdptr;
    end else if (state_reg == ST_ACCESS) begin
      ram_cs    = 1'b1;
      ram_we    = hold_we_reg;
      ram_addr  = hold_addr_reg;
      ram_wdata = hold_we_reg ? hold_wdata_reg : '0;
    end
    host_ack = (state_reg == ST_ACK);
  end

  assign host_rd_en     = host_ack & ~hold_we_reg;
  assign filt_coeff_vld = filt_vld_reg;

  // RAM read data is steered to whichever side issued the previous access.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rdata_gate
      assign filt_coeff[gi] = filt_vld_reg & ram_rdata[gi];
      assign host_rdata[gi] = host_rd_en & ram_rdata[gi];
    end
  endgenerate

`ifdef FILTER_COEFF_ARB_STARVE_EN
  filter_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk       (clk),
    .rstb      (rstb),
    .cnt_en    (arb_is_waiting(state_reg)),
    .cnt_clr   (state_reg == ST_ACK),
    .starve_clr(starve_clr),
    .starve    (host_starve)
  );
`else
  localparam int UNUSED_STARVE_LIMIT = STARVE_LIMIT;
  logic unused_starve_clr;
  assign unused_starve_clr = starve_clr;
  assign host_starve       = 1'b0;
`endif

endmodule

// File: tb/tb_filter_coeff_arb.sv
// Directed bench for filter_coeff_arb with a behavioural single-port RAM and a
// shadow coefficient model; starvation checks follow FILTER_COEFF_ARB_STARVE_EN.
module tb_filter_coeff_arb;

  localparam int PTR   = 9;
  localparam int WIDTH = 16;
`ifdef FILTER_COEFF_ARB_STARVE_EN
  localparam logic STARVE_EN = 1'b1;
`else
  localparam logic STARVE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             filt_re = 1'b0;
  logic [PTR-1:0]   filt_rdptr = '0;
  logic [WIDTH-1:0] filt_coeff;
  logic             filt_coeff_vld;
  logic             host_req = 1'b0;
  logic             host_we = 1'b0;
  logic [PTR-1:0]   host_addr = '0;
  logic [WIDTH-1:0] host_wdata = '0;
  logic             host_ack;
  logic [WIDTH-1:0] host_rdata;
  logic             ram_cs, ram_we;
  logic [PTR-1:0]   ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic             starve_clr = 1'b0;
  logic             host_starve;

  logic [WIDTH-1:0] mem   [512];
  logic [WIDTH-1:0] model [512];
  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int we_cnt = 0;

  filter_coeff_arb #(
    .PTR(PTR), .WIDTH(WIDTH), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rstb(rstb),
    .filt_re(filt_re), .filt_rdptr(filt_rdptr),
    .filt_coeff(filt_coeff), .filt_coeff_vld(filt_coeff_vld),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .starve_clr(starve_clr), .host_starve(host_starve)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM plus event counters.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
    if (host_ack) ack_cnt++;
    if (ram_cs && ram_we) we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Uncontended host access: cycle 0 request, 2 RAM access, 3 ack; returns
  // at the start of cycle 4 with host_req dropped.
  task automatic host_xfer(input logic we, input logic [PTR-1:0] addr,
                           input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] exp_rd);
    tick();
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    settle();
    chk("xfer_c0_cs", ram_cs, 0);
    tick(); settle();
    chk("xfer_c1_ack", host_ack, 0);
    chk("xfer_c1_cs", ram_cs, 0);
    tick(); settle();
    chk("xfer_c2_cs", ram_cs, 1);
    chk("xfer_c2_we", ram_we, we);
    chk("xfer_c2_addr", ram_addr, addr);
    chk("xfer_c2_wdata", ram_wdata, we ? wd : 16'h0);
    chk("xfer_c2_ack", host_ack, 0);
    tick(); settle();
    chk("xfer_c3_ack", host_ack, 1);
    chk("xfer_c3_rdata", host_rdata, we ? 16'h0 : exp_rd);
    if (we) model[addr] = wd;
    $display("txn host %s addr=%0d data=%h acked", we ? "wr" : "rd", addr, we ? wd : host_rdata);
    tick();
    host_req = 1'b0;
  endtask

  task automatic filt_read(input logic [PTR-1:0] addr, input string tag);
    filt_re = 1'b1; filt_rdptr = addr;
    settle();
    chk({tag, "_cs"}, ram_cs, 1);
    chk({tag, "_addr"}, ram_addr, addr);
    tick();
    filt_re = 1'b0;
    settle();
    chk({tag, "_vld"}, filt_coeff_vld, 1);
    chk({tag, "_coeff"}, filt_coeff, model[addr]);
    $display("txn filt rd addr=%0d coeff=%h", addr, filt_coeff);
  endtask

  initial begin
    int bad;
    int ack_base;
    int we_base;
    for (int i = 0; i < 512; i++) begin
      mem[i]   = 16'h1000 ^ 16'(i);
      model[i] = 16'h1000 ^ 16'(i);
    end
    mem[10]   = 16'h5A5A;
    model[10] = 16'h5A5A;

    // Reset state
    #2;
    chk("rst_vld", filt_coeff_vld, 0);
    chk("rst_coeff", filt_coeff, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_starve", host_starve, 0);
    tick(); tick();
    rstb = 1'b1;

    // Host write addr 5, then filter reads the new value
    host_xfer(1'b1, 9'd5, 16'h1234, 16'h0);
    settle();
    chk("a_c4_ack", host_ack, 0);
    filt_read(9'd5, "a_fr5");

    // Filter read in the cycle right after a host write (ack cycle)
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 9'd7; host_wdata = 16'hBEEF;
    tick(); tick(); tick();
    filt_re = 1'b1; filt_rdptr = 9'd7;
    settle();
    chk("b_c3_ack", host_ack, 1);
    chk("b_c3_cs_filt", ram_addr, 9'd7);
    model[7] = 16'hBEEF;
    $display("txn host wr addr=7 data=beef acked");
    tick();
    host_req = 1'b0; filt_re = 1'b0;
    settle();
    chk("b_c4_coeff", filt_coeff, 16'hBEEF);

    // Host read addr 10 during a 512-cycle filter burst
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 9'd10;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      filt_re = 1'b1; filt_rdptr = 9'(i);
      settle();
      if (!ram_cs || ram_we || ram_addr != 9'(i) || host_ack) bad++;
      if (i > 0 && (!filt_coeff_vld || filt_coeff != model[i-1])) bad++;
      if (i == 8) chk("c_starve_c8", host_starve, 0);
      if (i == 9) chk("c_starve_c9", host_starve, STARVE_EN);
      tick();
    end
    chk("c_burst_errs", bad, 0);
    filt_re = 1'b0;
    settle();
    chk("c_f0_vld", filt_coeff_vld, 1);
    chk("c_f0_coeff", filt_coeff, model[511]);
    chk("c_f0_ack", host_ack, 0);
    chk("c_f0_cs", ram_cs, 0);
    tick(); settle();
    chk("c_f1_cs", ram_cs, 1);
    chk("c_f1_we", ram_we, 0);
    chk("c_f1_addr", ram_addr, 9'd10);
    chk("c_f1_ack", host_ack, 0);
    tick(); settle();
    chk("c_f2_ack", host_ack, 1);
    chk("c_f2_rdata", host_rdata, 16'h5A5A);
    $display("txn host rd addr=10 data=%h acked after burst", host_rdata);
    tick();
    host_req = 1'b0; starve_clr = 1'b1;
    settle();
    chk("c_starve_hold", host_starve, STARVE_EN);
    tick();
    starve_clr = 1'b0;
    settle();
    chk("c_starve_clr", host_starve, 0);

    // Filter takes the ACCESS cycle; host access deferred
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 9'd20; host_wdata = 16'hCAFE;
    tick(); tick();
    filt_re = 1'b1; filt_rdptr = 9'd20;
    settle();
    chk("d_c2_we", ram_we, 0);
    chk("d_c2_addr", ram_addr, 9'd20);
    tick();
    filt_re = 1'b0;
    settle();
    chk("d_c3_ack", host_ack, 0);
    chk("d_c3_cs", ram_cs, 0);
    chk("d_c3_coeff", filt_coeff, 16'h1014);
    tick(); settle();
    chk("d_c4_we", ram_we, 1);
    chk("d_c4_wdata", ram_wdata, 16'hCAFE);
    tick(); settle();
    chk("d_c5_ack", host_ack, 1);
    model[20] = 16'hCAFE;
    $display("txn host wr addr=20 data=cafe acked after retry");
    tick();
    host_req = 1'b0;
    filt_read(9'd20, "d_fr20");

    // Top address, write then read back through the host port
    host_xfer(1'b1, 9'd511, 16'h7FFF, 16'h0);
    host_xfer(1'b0, 9'd511, 16'h0, 16'h7FFF);

    // Reset while a write is pending
    host_xfer(1'b0, 9'd5, 16'h0, 16'h1234);
    host_req = 1'b1; host_we = 1'b1; host_addr = 9'd30; host_wdata = 16'hDEAD;
    tick();
    ack_base = ack_cnt; we_base = we_cnt;
    #4 rstb = 1'b0;
    #1;
    host_req = 1'b0;
    chk("e_rst_cs", ram_cs, 0);
    chk("e_rst_ack", host_ack, 0);
    chk("e_rst_vld", filt_coeff_vld, 0);
    chk("e_rst_rdata", host_rdata, 0);
    tick(); tick();
    rstb = 1'b1;
    tick(); tick(); tick(); tick();
    chk("e_no_ack", ack_cnt - ack_base, 0);
    chk("e_no_we", we_cnt - we_base, 0);
    filt_read(9'd30, "e_fr30");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/filter_coeff_arb.md
FILTER_COEFF_ARB -- requirements
Module: filter_coeff_arb

Interface
REQ-001 The block SHALL have parameter PTR, default 9, meaning coefficient address width (512 taps).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning coefficient data width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 1023, meaning host-wait cycles before the starve flag sets.
REQ-004 clk  input  1  clock; all state on posedge clk.
REQ-005 rstb  input  1  reset, asynchronous, active-low.
REQ-006 filt_re  input  1  filter engine coefficient read enable.
REQ-007 filt_rdptr  input  PTR  filter coefficient read address.
REQ-008 filt_coeff  output  WIDTH  coefficient returned to the filter.
REQ-009 filt_coeff_vld  output  1  filt_coeff valid this cycle.
REQ-010 host_req  input  1  register-file access request; held until host_ack.
REQ-011 host_we  input  1  1 = write, 0 = read; stable while host_req is high.
REQ-012 host_addr  input  PTR  host coefficient address.
REQ-013 host_wdata  input  WIDTH  host write data.
REQ-014 host_ack  output  1  one-cycle completion pulse.
REQ-015 host_rdata  output  WIDTH  read data, valid only while host_ack is high with a read.
REQ-016 ram_cs, ram_we  output  1 each  single-port coefficient RAM chip select / write enable.
REQ-017 ram_addr  output  PTR; ram_wdata  output  WIDTH; ram_rdata  input  WIDTH (synchronous read, data one cycle after ram_cs).
REQ-018 starve_clr  input  1  clears starve flag; host_starve  output  1  sticky starvation flag.

Function
REQ-019 Filter SHALL have strict priority: when filt_re=1, ram_cs=1, ram_we=0, ram_addr=filt_rdptr combinationally in that cycle.
REQ-020 filt_coeff_vld SHALL be 1 exactly one cycle after each cycle with filt_re=1, with filt_coeff=ram_rdata; otherwise filt_coeff=0 and filt_coeff_vld=0.
REQ-021 FSM states SHALL be IDLE, PEND, ACCESS, ACK (one-hot).
REQ-022 IDLE: host_req=1 -> capture host_we/host_addr/host_wdata into holding registers, go to PEND.
REQ-023 PEND: filt_re=0 -> go to ACCESS; filt_re=1 -> remain in PEND.
REQ-024 ACCESS: RAM driven from holding registers (ram_cs=1, ram_we=held we) only if filt_re=0 in that cycle, then go to ACK; if filt_re=1, filter wins, return to PEND with no host access.
REQ-025 ACK: host_ack=1 for one cycle; for reads host_rdata=ram_rdata; go to IDLE; host_req sampled in ACK SHALL be ignored (new request accepted from IDLE next cycle).
REQ-026 Minimum host latency SHALL be 3 cycles from host_req rise to host_ack (IDLE->PEND->ACCESS->ACK).
REQ-027 ram_cs SHALL never be asserted for host and filter in the same cycle; no access in any other cycle (ram_cs=0, ram_addr=0, ram_wdata=0).
REQ-028 Host write to address currently read by the filter in the same cycle SHALL be impossible by REQ-019; filter reads in the cycle after a host write SHALL return the new value.
REQ-029 Address wrap: filt_rdptr and host_addr are unsigned PTR-bit; no range check, 511 valid.

Reset
REQ-030 On rstb=0: state IDLE, holding registers 0, filt_coeff=0, filt_coeff_vld=0, host_ack=0, host_rdata=0, host_starve=0, starve counter 0.
REQ-031 Reset mid-request SHALL drop the pending host access with no RAM write and no host_ack.

Configuration
REQ-032 With FILTER_COEFF_ARB_STARVE_EN defined: counter increments each cycle in PEND/ACCESS, clears on ACK; when counter reaches STARVE_LIMIT, host_starve sets and holds until starve_clr=1 (starve_clr wins over simultaneous set).
REQ-033 Without FILTER_COEFF_ARB_STARVE_EN: no counter, host_starve tied 0, starve_clr ignored, STARVE_LIMIT unused.

Structure
REQ-034 FSM state encodings, PTR/WIDTH defaults shared with the filter controller SHALL live in a shared filter package.
REQ-035 Starvation counter SHALL be a sub-module filter_starve_cnt (instantiated only when macro defined); RAM remains external.

Verification
REQ-036 Host write addr 5 = 0x1234 with filt_re=0 -> ram_we pulse at cycle 2, host_ack at cycle 3; later filter read addr 5 -> filt_coeff=0x1234 next cycle.
REQ-037 Host read addr 10 during 512-cycle filt_re burst -> no host RAM access during burst, host_ack 2 cycles after filt_re falls, correct data.
REQ-038 filt_re asserted in the ACCESS cycle -> filter served, host returns to PEND, ack delayed, data unchanged.
REQ-039 Macro defined, STARVE_LIMIT=8, filt_re held 20 cycles with host pending -> host_starve=1 at 8th wait cycle, stays after ack, clears on starve_clr.
REQ-040 rstb low while in PEND with write pending -> no ram_we, no host_ack, all outputs 0.
